// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, control bundle, MD FSM states.
package ex_stage_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MD_CYCLES_DEF = 32;
  localparam int unsigned OP_W          = 6;
  localparam int unsigned REG_W         = 5;

  localparam logic [OP_W-1:0]
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_ADDU  = 6'd2,  OP_SUB  = 6'd3,
    OP_SUBU = 6'd4,  OP_AND  = 6'd5,  OP_OR    = 6'd6,  OP_XOR  = 6'd7,
    OP_NOR  = 6'd8,  OP_SLT  = 6'd9,  OP_SLTU  = 6'd10, OP_SLL  = 6'd11,
    OP_SRL  = 6'd12, OP_SRA  = 6'd13, OP_SLLV  = 6'd14, OP_SRLV = 6'd15,
    OP_SRAV = 6'd16, OP_LUI  = 6'd17, OP_BEQ   = 6'd18, OP_BNE  = 6'd19,
    OP_J    = 6'd20, OP_JAL  = 6'd21, OP_JR    = 6'd22, OP_LW   = 6'd23,
    OP_SW   = 6'd24, OP_MULT = 6'd25, OP_MULTU = 6'd26, OP_DIV  = 6'd27,
    OP_DIVU = 6'd28, OP_MFHI = 6'd29, OP_MFLO  = 6'd30;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Decoded control bundle carried through ID/EX; all-zero is a bubble.
  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic            branch;
    logic            jump;
    logic            alusrc;
    logic            regdst;
    logic [OP_W-1:0] aluop;
  } ctrl_t;

  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle, owns HI/LO.
module md_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              stall_c_o,
  output logic              idle_c_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam int unsigned PW    = 2 * DATA_W;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] r_q, r_d, q_q, q_d, m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;

  logic [DATA_W:0]   mul_sum, div_rs;
  logic [DATA_W-1:0] div_dif, step_r, step_q, quo_fix, rem_fix;
  logic              div_ge, sgn, a_neg, b_neg;
  logic [PW-1:0]     prod, prod_fix;

  // One iteration of the selected algorithm on the {r, q} pair.
  always_comb begin
    mul_sum = {1'b0, r_q} + {1'b0, m_q & {DATA_W{q_q[0]}}};
    div_rs  = {r_q, q_q[DATA_W-1]};
    div_ge  = (div_rs >= {1'b0, m_q});
    div_dif = div_rs[DATA_W-1:0] - m_q;
    if (is_div_q) begin
      step_r = div_ge ? div_dif : div_rs[DATA_W-1:0];
      step_q = {q_q[DATA_W-2:0], div_ge};
    end else begin
      step_r = mul_sum[DATA_W:1];
      step_q = {mul_sum[0], q_q[DATA_W-1:1]};
    end
    prod     = {step_r, step_q};
    prod_fix = neg_res_q ? (~prod + PW'(1)) : prod;
    quo_fix  = neg_res_q ? (~step_q + DATA_W'(1)) : step_q;
    rem_fix  = neg_rem_q ? (~step_r + DATA_W'(1)) : step_r;
  end

  // FSM next state, operand capture and HI/LO write-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    m_d       = m_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    stall_c_o = 1'b0;
    sgn       = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg     = sgn & rs_i[DATA_W-1];
    b_neg     = sgn & rt_i[DATA_W-1];
    unique case (state_q)
      MD_IDLE: begin
        if (is_md_op(op_i)) begin
          stall_c_o = 1'b1;
          state_d   = MD_BUSY;
          cnt_d     = CNT_W'(MD_CYCLES - 1);
          r_d       = '0;
          q_d       = a_neg ? (~rs_i + DATA_W'(1)) : rs_i;
          m_d       = b_neg ? (~rt_i + DATA_W'(1)) : rt_i;
          a_d       = rs_i;
          is_div_d  = (op_i == OP_DIV) || (op_i == OP_DIVU);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (rt_i == '0);
        end
      end
      MD_BUSY: begin
        stall_c_o = 1'b1;
        r_d       = step_r;
        q_d       = step_q;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
          if (!is_div_q) begin
            hi_d = prod_fix[PW-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end else if (div0_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      m_q       <= m_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign idle_c_o = (state_q == MD_IDLE);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, branch/jump targets, and the mult/div unit.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic [OP_W-1:0]   ALUopD,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] SignImm_in,
  input  logic [REG_W-1:0]  shamt_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] PCPlus4_in,
  input  logic [DATA_W-1:0] JumpAddr_in,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [OP_W-1:0]   ALUopE,
  output logic [DATA_W-1:0] ALUOut_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [DATA_W-1:0] PCPlus4_out,
  output logic [DATA_W-1:0] PCBranch_out,
  output logic [REG_W-1:0]  wb_addr_out,
  output logic              StallE
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d, jaddr_q, jaddr_d;
  logic [REG_W-1:0]  shamt_q, shamt_d, rt_q, rt_d, rd_q, rd_d;

  logic              stall_c, md_idle_c, bubble_c;
  logic [DATA_W-1:0] hi, lo, srcb_c, alu_c;

  md_unit #(.DATA_W(DATA_W), .MD_CYCLES(MD_CYCLES)) u_md (
    .clk       (CLK),
    .rst_n     (RESET_n),
    .flush_i   (FlushE),
    .op_i      (ctrl_q.aluop),
    .rs_i      (rd1_q),
    .rt_i      (rd2_q),
    .stall_c_o (stall_c),
    .idle_c_o  (md_idle_c),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  // ID/EX next value: flush beats stall, stall holds.
  always_comb begin
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    jaddr_d = jaddr_q;
    shamt_d = shamt_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    if (FlushE) begin
      ctrl_d  = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc4_d   = '0;
      jaddr_d = '0;
      shamt_d = '0;
      rt_d    = '0;
      rd_d    = '0;
    end else if (!stall_c) begin
      ctrl_d.regwrite = RegWriteD;
      ctrl_d.memtoreg = MemtoRegD;
      ctrl_d.memwrite = MemWriteD;
      ctrl_d.branch   = BranchD;
      ctrl_d.jump     = JumpD;
      ctrl_d.alusrc   = ALUSrcD;
      ctrl_d.regdst   = RegDstD;
      ctrl_d.aluop    = ALUopD;
      rd1_d   = RD1_in;
      rd2_d   = RD2_in;
      imm_d   = SignImm_in;
      pc4_d   = PCPlus4_in;
      jaddr_d = JumpAddr_in;
      shamt_d = shamt_in;
      rt_d    = rt_in;
      rd_d    = rd_in;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      jaddr_q <= '0;
      shamt_q <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      jaddr_q <= jaddr_d;
      shamt_q <= shamt_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  // ALU; shifts operate on rt, branch compares always use rt.
  always_comb begin
    srcb_c = ctrl_q.alusrc ? imm_q : rd2_q;
    alu_c  = '0;
    unique case (ctrl_q.aluop)
      OP_ADD, OP_ADDU, OP_LW, OP_SW: alu_c = rd1_q + srcb_c;
      OP_SUB, OP_SUBU: alu_c = rd1_q - srcb_c;
      OP_AND:  alu_c = rd1_q & srcb_c;
      OP_OR:   alu_c = rd1_q | srcb_c;
      OP_XOR:  alu_c = rd1_q ^ srcb_c;
      OP_NOR:  alu_c = ~(rd1_q | srcb_c);
      OP_SLT:  alu_c = DATA_W'($signed(rd1_q) < $signed(srcb_c));
      OP_SLTU: alu_c = DATA_W'(rd1_q < srcb_c);
      OP_SLL:  alu_c = rd2_q << shamt_q;
      OP_SRL:  alu_c = rd2_q >> shamt_q;
      OP_SRA:  alu_c = DATA_W'($signed(rd2_q) >>> shamt_q);
      OP_SLLV: alu_c = rd2_q << rd1_q[REG_W-1:0];
      OP_SRLV: alu_c = rd2_q >> rd1_q[REG_W-1:0];
      OP_SRAV: alu_c = DATA_W'($signed(rd2_q) >>> rd1_q[REG_W-1:0]);
      OP_LUI:  alu_c = imm_q << 16;
      OP_BEQ:  alu_c = DATA_W'(rd1_q == rd2_q);
      OP_BNE:  alu_c = DATA_W'(rd1_q != rd2_q);
      OP_J, OP_JAL: alu_c = jaddr_q;
      OP_JR:   alu_c = rd1_q;
      OP_MFHI: alu_c = hi;
      OP_MFLO: alu_c = lo;
      default: alu_c = '0;
    endcase
  end

  assign bubble_c = !md_idle_c || is_md_op(ctrl_q.aluop);
  assign StallE   = stall_c;

  // Outputs to MEM; an MD op in flight presents a bubble.
  always_comb begin
    RegWriteE     = 1'b0;
    MemtoRegE     = 1'b0;
    MemWriteE     = 1'b0;
    BranchE       = 1'b0;
    JumpE         = 1'b0;
    ALUopE        = OP_NOP;
    ALUOut_out    = '0;
    WriteData_out = '0;
    PCPlus4_out   = '0;
    PCBranch_out  = '0;
    wb_addr_out   = '0;
    if (!bubble_c) begin
      RegWriteE     = ctrl_q.regwrite;
      MemtoRegE     = ctrl_q.memtoreg;
      MemWriteE     = ctrl_q.memwrite;
      BranchE       = ctrl_q.branch;
      JumpE         = ctrl_q.jump;
      ALUopE        = ctrl_q.aluop;
      ALUOut_out    = alu_c;
      WriteData_out = rd2_q;
      PCPlus4_out   = pc4_q;
      PCBranch_out  = pc4_q + (imm_q << 2);
      wb_addr_out   = (ctrl_q.aluop == OP_JAL) ? REG_W'(31) : (ctrl_q.regdst ? rd_q : rt_q);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed test of the execute stage: ALU ops, branch/jump, mult/div stall, flush and reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        CLK, RESET_n, FlushE;
  logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, ALUSrcD, RegDstD;
  logic [5:0]  ALUopD;
  logic [31:0] RD1_in, RD2_in, SignImm_in, PCPlus4_in, JumpAddr_in;
  logic [4:0]  shamt_in, rt_in, rd_in;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, StallE;
  logic [5:0]  ALUopE;
  logic [31:0] ALUOut_out, WriteData_out, PCPlus4_out, PCBranch_out;
  logic [4:0]  wb_addr_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_stall;
  logic bub_ok;

  ex_stage dut (
    .CLK(CLK), .RESET_n(RESET_n), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .RD1_in(RD1_in), .RD2_in(RD2_in), .SignImm_in(SignImm_in),
    .shamt_in(shamt_in), .rt_in(rt_in), .rd_in(rd_in), .PCPlus4_in(PCPlus4_in),
    .JumpAddr_in(JumpAddr_in),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUopE(ALUopE), .ALUOut_out(ALUOut_out),
    .WriteData_out(WriteData_out), .PCPlus4_out(PCPlus4_out),
    .PCBranch_out(PCBranch_out), .wb_addr_out(wb_addr_out), .StallE(StallE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_d();
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0;
    ALUSrcD = 0; RegDstD = 0; ALUopD = OP_NOP;
    RD1_in = 0; RD2_in = 0; SignImm_in = 0; PCPlus4_in = 0; JumpAddr_in = 0;
    shamt_in = 0; rt_in = 0; rd_in = 0;
  endtask

  // Present a HI/LO read as the next instruction (held by the stage while stalled).
  task automatic next_mf(input logic [5:0] op);
    clear_d();
    ALUopD = op; RegWriteD = 1; RegDstD = 1; rd_in = 5'd9;
  endtask

  // Count stall cycles (bounded) and confirm MEM sees a bubble throughout.
  task automatic wait_md(output int n, output logic ok);
    n = 0;
    ok = 1'b1;
    while (StallE && n < 200) begin
      if (RegWriteE || MemWriteE || BranchE || JumpE || ALUOut_out != 0 || ALUopE != OP_NOP) ok = 1'b0;
      n++;
      tick();
    end
    if (RegWriteE || MemWriteE || BranchE || JumpE || ALUOut_out != 0) ok = 1'b0;
  endtask

  task automatic start_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_d();
    ALUopD = op; RD1_in = a; RD2_in = b;
    tick();
  endtask

  initial begin
    RESET_n = 1'b0;
    FlushE  = 1'b0;
    clear_d();
    #1;
    chk("rst_aluout", ALUOut_out, 32'h0);
    chk("rst_stall", 32'(StallE), 32'h0);
    chk("rst_regwrite", 32'(RegWriteE), 32'h0);
    chk("rst_pcbranch", PCBranch_out, 32'h0);
    #11 RESET_n = 1'b1;

    // add with wraparound
    clear_d();
    ALUopD = OP_ADD; RD1_in = 32'd5; RD2_in = 32'hFFFF_FFFF; RegDstD = 1; rd_in = 5'd8; rt_in = 5'd3; RegWriteD = 1;
    tick();
    chk("add_out", ALUOut_out, 32'd4);
    chk("add_wb", 32'(wb_addr_out), 32'd8);
    chk("add_rw", 32'(RegWriteE), 32'd1);
    chk("add_stall", 32'(StallE), 32'd0);

    // beq taken, backward target
    clear_d();
    ALUopD = OP_BEQ; BranchD = 1; RD1_in = 32'd7; RD2_in = 32'd7; SignImm_in = 32'hFFFF_FFFE; PCPlus4_in = 32'h40;
    tick();
    chk("beq_out", ALUOut_out, 32'd1);
    chk("beq_br", 32'(BranchE), 32'd1);
    chk("beq_target", PCBranch_out, 32'h38);
    ALUopD = OP_BNE;
    tick();
    chk("bne_out", ALUOut_out, 32'd0);

    // jal links to r31
    clear_d();
    ALUopD = OP_JAL; JumpD = 1; RegWriteD = 1; JumpAddr_in = 32'h0040_0100; PCPlus4_in = 32'h24; rt_in = 5'd4;
    tick();
    chk("jal_out", ALUOut_out, 32'h0040_0100);
    chk("jal_jump", 32'(JumpE), 32'd1);
    chk("jal_wb", 32'(wb_addr_out), 32'd31);
    chk("jal_pc4", PCPlus4_out, 32'h24);

    // sw address and store data
    clear_d();
    ALUopD = OP_SW; MemWriteD = 1; ALUSrcD = 1; RD1_in = 32'h1000; RD2_in = 32'hABCD; SignImm_in = 32'hFFFF_FFFC;
    tick();
    chk("sw_addr", ALUOut_out, 32'h0FFC);
    chk("sw_data", WriteData_out, 32'hABCD);
    chk("sw_memwrite", 32'(MemWriteE), 32'd1);

    // assorted ALU ops
    clear_d(); ALUopD = OP_SRA; RD2_in = 32'h8000_0000; shamt_in = 5'd4; tick();
    chk("sra", ALUOut_out, 32'hF800_0000);
    clear_d(); ALUopD = OP_SLT; RD1_in = 32'hFFFF_FFFF; RD2_in = 32'd1; tick();
    chk("slt", ALUOut_out, 32'd1);
    ALUopD = OP_SLTU; tick();
    chk("sltu", ALUOut_out, 32'd0);
    clear_d(); ALUopD = OP_LUI; ALUSrcD = 1; SignImm_in = 32'h1234; tick();
    chk("lui", ALUOut_out, 32'h1234_0000);
    clear_d(); ALUopD = OP_SLLV; RD1_in = 32'h23; RD2_in = 32'd1; tick();
    chk("sllv", ALUOut_out, 32'd8);
    clear_d(); ALUopD = OP_NOR; RD1_in = 32'h0F0F_0000; RD2_in = 32'h0000_00FF; tick();
    chk("nor", ALUOut_out, 32'hF0F0_FF00);

    // signed mult -3*7, followed by mflo/mfhi
    start_md(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    next_mf(OP_MFLO);
    wait_md(n_stall, bub_ok);
    chk("mult_stalls", 32'(n_stall), 32'd33);
    chk("mult_bubble", 32'(bub_ok), 32'd1);
    tick();
    chk("mult_lo", ALUOut_out, 32'hFFFF_FFEB);
    chk("mflo_wb", 32'(wb_addr_out), 32'd9);
    next_mf(OP_MFHI); tick();
    chk("mult_hi", ALUOut_out, 32'hFFFF_FFFF);

    // divu by zero
    start_md(OP_DIVU, 32'd100, 32'd0);
    next_mf(OP_MFLO);
    wait_md(n_stall, bub_ok);
    chk("divu0_stalls", 32'(n_stall), 32'd33);
    tick();
    chk("divu0_lo", ALUOut_out, 32'hFFFF_FFFF);
    next_mf(OP_MFHI); tick();
    chk("divu0_hi", ALUOut_out, 32'd100);

    // signed div -7/2
    start_md(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    next_mf(OP_MFLO);
    wait_md(n_stall, bub_ok);
    chk("div_bubble", 32'(bub_ok), 32'd1);
    tick();
    chk("div_lo", ALUOut_out, 32'hFFFF_FFFD);
    next_mf(OP_MFHI); tick();
    chk("div_hi", ALUOut_out, 32'hFFFF_FFFF);

    // multu with both halves nonzero
    start_md(OP_MULTU, 32'h0001_0001, 32'h0003_0000);
    next_mf(OP_MFLO);
    wait_md(n_stall, bub_ok);
    tick();
    chk("multu_lo", ALUOut_out, 32'h0003_0000);
    next_mf(OP_MFHI); tick();
    chk("multu_hi", ALUOut_out, 32'd3);

    // flush in BUSY cycle 10 of a div aborts it
    start_md(OP_DIV, 32'd1000, 32'd7);
    next_mf(OP_MFLO);
    repeat (10) tick();
    FlushE = 1'b1;
    chk("flush_stall_hold", 32'(StallE), 32'd1);
    tick();
    FlushE = 1'b0;
    chk("flush_stall_drop", 32'(StallE), 32'd0);
    chk("flush_bubble", ALUOut_out, 32'd0);
    tick();
    chk("flush_lo_kept", ALUOut_out, 32'h0003_0000);
    next_mf(OP_MFHI); tick();
    chk("flush_hi_kept", ALUOut_out, 32'd3);

    // async reset in the middle of a mult
    start_md(OP_MULT, 32'd3, 32'd4);
    next_mf(OP_MFLO);
    repeat (5) tick();
    RESET_n = 1'b0;
    #1;
    chk("rstmid_stall", 32'(StallE), 32'd0);
    chk("rstmid_aluout", ALUOut_out, 32'd0);
    chk("rstmid_alop", 32'(ALUopE), 32'(OP_NOP));
    #2 RESET_n = 1'b1;
    tick();
    chk("rstmid_lo", ALUOut_out, 32'd0);
    next_mf(OP_MFHI); tick();
    chk("rstmid_hi", ALUOut_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It sits between ID and MEM_stage, holds the ID/EX pipeline register, and runs the ALU. It computes the branch target and computes or selects the jump target. It owns HI/LO with an iterative multiply/divide unit that stalls the front end while busy. Its outputs are combinational from the ID/EX register; MEM_stage registers them (EX/MEM).

Parameters:
DATA_W, 32, datapath width
MD_CYCLES, 32, iterations per mult/div (one bit per cycle)

Ports:
CLK  in  1  clock, rising edge
RESET_n  in  1  asynchronous active-low reset
FlushE  in  1  from MEM_stage PCSrcM; squash the instruction entering EX
RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, ALUSrcD, RegDstD  in  1 each  decoded controls
ALUopD  in  6  operation code (shared package)
RD1_in, RD2_in  in  32  register operands rs, rt
SignImm_in  in  32  sign-extended immediate
shamt_in  in  5  shift amount
rt_in, rd_in  in  5  destination candidates
PCPlus4_in  in  32  PC+4
JumpAddr_in  in  32  {PC+4[31:28], index, 2'b00} for j/jal
RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE  out  1 each  to MEM_stage
ALUopE  out  6  to MEM_stage
ALUOut_out, WriteData_out, PCPlus4_out, PCBranch_out  out  32  to MEM_stage
wb_addr_out  out  5  to MEM_stage
StallE  out  1  hold PC, IF/ID, and ID/EX inputs (front end)

Behaviour:
- Reset (async, RESET_n=0): ID/EX holds a bubble (all controls 0, ALUop=OP_NOP, data 0); MD FSM=IDLE; HI=LO=0; StallE=0; all outputs 0.
- ID/EX register, posedge CLK: FlushE=1 loads a bubble and aborts any MD operation (FSM→IDLE, HI/LO unchanged). FlushE has priority over stall. Otherwise, if StallE=0, load the D inputs; else hold.
- ALU, operand B = ALUSrc ? SignImm : RD2.
- ALU ops: add/addu/sub/subu wrap mod 2^32 with no traps; and/or/xor/nor; slt signed; sltu; sll/srl/sra by shamt; sllv/srlv/srav by RD1[4:0]; lui = imm<<16.
- Branches: beq gives ALUOut=(RD1==RD2); bne gives ALUOut=(RD1!=RD2). Both always use RD2. MEM_stage takes the branch when BranchE=1 and ALUOut==1.
- Jumps: j/jal give ALUOut=JumpAddr_in; jr gives ALUOut=RD1.
- lw/sw: ALUOut = RD1+SignImm. mfhi/mflo: ALUOut = HI/LO.
- PCBranch_out = PCPlus4 + (SignImm<<2) mod 2^32. WriteData_out = RD2 after the ID/EX register.
- wb_addr_out = 31 for jal; otherwise RegDst ? rd : rt.
- MD FSM states: IDLE, BUSY, DONE.
  - IDLE: in cycle t, ID/EX holds mult/multu/div/divu. StallE=1; load operands (magnitudes for signed ops) and count=MD_CYCLES-1; →BUSY.
  - BUSY: one shift-add or restoring-subtract step per cycle; StallE=1. At count==0, sign-correct and write HI/LO; →DONE. Count decrements otherwise.
  - DONE: StallE=0. The instruction leaves EX as a bubble to MEM (RegWrite/MemWrite/Branch/Jump=0). →IDLE.
  - Total StallE=1 cycles: MD_CYCLES+1.
- Whenever the FSM is not IDLE, or ID/EX holds an MD op, outputs to MEM are forced to a bubble.
- Results: mult/multu give {HI,LO} = 64-bit product. div/divu give LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO=32'hFFFFFFFF, HI=RD1; still takes the full MD_CYCLES.
- mfhi/mflo directly after mult/div read the new value, since ID/EX does not advance before DONE.
- Reset mid-operation: immediate return to the reset state; HI/LO=0.

Decomposition:
- Shared package: ALUop constants (OP_NOP, OP_ADD ... OP_MFLO), DATA_W default, MD state encoding.
- Natural sub-module: md_unit (FSM, counter, HI/LO, signed correction). The ALU and ID/EX register stay in ex_stage.

Test Plan:
- add: RD1=5, RD2=32'hFFFFFFFF, ALUSrc=0, RegDst=1, rd=8 -> next cycle ALUOut=4, wb_addr=8, RegWriteE=1, StallE=0.
- beq taken: RD1=RD2=7, SignImm=-2, PCPlus4=0x40 -> ALUOut=1, BranchE=1, PCBranch=0x38. The same case with bne gives ALUOut=0.
- jal: JumpAddr=0x0040_0100, PCPlus4=0x24 -> ALUOut=0x0040_0100, JumpE=1, wb_addr=31, PCPlus4_out=0x24.
- mult: RD1=-3, RD2=7, followed by mflo -> StallE high exactly 33 cycles and bubble to MEM meanwhile; then HI=FFFFFFFF, LO=FFFFFFEB; mflo gives ALUOut=FFFFFFEB.
- divu: RD1=100, RD2=0 -> after 33 stall cycles LO=FFFFFFFF, HI=100. Signed div -7/2 -> LO=-3, HI=-1.
- Abort and reset: FlushE=1 in BUSY cycle 10 of a div -> StallE drops next cycle, HI/LO unchanged. Separately, RESET_n=0 mid-mult -> outputs 0, HI=LO=0, StallE=0 immediately.
